palabra_8_32_rx: RTL and testbench
==================================

PALABRA_8_32_RX -- requirements
Module: palabra_8_32_rx

Interface
REQ-001 Parameter COM, default 8'hBC, comma/idle symbol used for lane sync and idle fill.
REQ-002 Parameter SYNC_CNT, default 4, number of consecutive COM bytes required to declare sync.
REQ-003 clk_4f  input  1  sole clock; every register SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk_4f.
REQ-005 data_in  input  8  byte from the serial-to-parallel receiver stage.
REQ-006 valid_in  input  1  byte strobe; data_in is consumed only on edges where valid_in=1, and gaps of any length are allowed.
REQ-007 data_out  output  32  assembled word, first received byte in [31:24].
REQ-008 valid_out  output  1  one-cycle pulse marking a new data_out.
REQ-009 active  output  1  lane synchronized.
REQ-010 error_out  output  1  one-cycle pulse on a discarded partial word.
REQ-011 err_count  output  8  saturating count of error_out pulses.

Function
REQ-012 The block SHALL implement FSM states SEEK and SYNC; only valid_in=1 edges advance the FSM or counters.
REQ-013 In SEEK, a byte equal to COM SHALL increment com_cnt; any other byte SHALL clear com_cnt to 0.
REQ-014 In SEEK, when the SYNC_CNT-th consecutive COM is accepted, the FSM SHALL enter SYNC, with active=1 from the next edge onward.
REQ-015 In SEEK, no byte SHALL be assembled, and valid_out and error_out SHALL remain 0.
REQ-016 In SYNC, a COM byte with byte_cnt=0 SHALL be discarded as idle, with no output change.
REQ-017 In SYNC, a non-COM byte SHALL be stored in lane byte_cnt (0 maps to [31:24], 3 maps to [7:0]), and byte_cnt SHALL increment modulo 4.
REQ-018 On acceptance of the 4th byte, data_out SHALL load the complete word and valid_out SHALL be 1 for exactly the next cycle (latency 1 clock from the 4th byte edge).
REQ-019 data_out SHALL hold its last value until the next completed word; partial assembly SHALL use an internal shadow register and never alter data_out.
REQ-020 In SYNC, a COM byte with byte_cnt 1..3 SHALL discard the partial word, clear byte_cnt to 0, pulse error_out for one cycle, and increment err_count.
REQ-021 err_count SHALL saturate at 8'hFF.
REQ-022 Back-to-back words (valid_in high continuously) SHALL produce valid_out every 4th cycle with no lost bytes.
REQ-023 Once in SYNC, the block SHALL stay in SYNC until reset; there is no loss-of-sync detection.
REQ-024 The arrival of the 4th byte and a new first byte are mutually exclusive per edge (one byte per edge), so no simultaneous-event arbitration is needed.

Reset
REQ-025 While reset=1 on an edge, the block SHALL set state=SEEK, com_cnt=0, byte_cnt=0, shadow=0, data_out=32'h0, valid_out=0, active=0, error_out=0, and err_count=0.
REQ-026 Reset asserted mid-word or mid-sync-search SHALL discard all progress; inputs on that edge SHALL be ignored.
REQ-027 After reset deassertion, the first valid_in edge SHALL be processed normally in SEEK.

Verification
REQ-028 Sync: the bench SHALL drive BC,BC,BC,BC (valid_in=1 each edge), then F2,15,DD,45; required response: active=1 after the 4th BC, data_out=32'hF215DD45, and valid_out pulsing once, 1 clock after the 45.
REQ-029 Idle and second word: after REQ-028, the bench SHALL drive BC x4, then AA,EE,13,CD; required response: no valid_out during the BCs, then data_out=32'hAAEE13CD and a single valid_out pulse.
REQ-030 Broken sync search: from reset, the bench SHALL drive BC,BC,BC,F2,BC,BC,BC,BC; required response: active stays 0 through the F2 and goes 1 only after the final BC.
REQ-031 Partial word: in SYNC, the bench SHALL drive AA,EE,BC, then 13,CD,45,DD; required response: error_out pulses once, err_count=1, data_out is unchanged until it becomes 32'h13CD45DD.
REQ-032 Gapped strobes: in SYNC, the bench SHALL drive F2,15,DD,45 with valid_in low for 7 cycles between bytes; required response: data_out=32'hF215DD45, exactly one valid_out pulse, and nothing during the gaps.
REQ-033 Reset mid-word: in SYNC after F2,15, the bench SHALL assert reset for 1 cycle; required response: all outputs return to 0, and the subsequent DD,45 do not produce valid_out until a new sync is achieved.

Source files
------------

// File: rtl/palabra_8_32_rx.sv
// Byte-to-word lane receiver: locks onto a run of COM symbols, then packs
// non-COM bytes into 32-bit words (first byte in [31:24]), flagging broken words.
module palabra_8_32_rx #(
  parameter logic [7:0]  COM      = 8'hBC,
  parameter int unsigned SYNC_CNT = 4
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active,
  output logic        error_out,
  output logic [7:0]  err_count
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned ERR_W  = 8;
  localparam int unsigned CNT_W  = (SYNC_CNT > 1) ? $clog2(SYNC_CNT) : 1;

  localparam logic [CNT_W-1:0]  COM_LAST  = CNT_W'(SYNC_CNT - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(3);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic {
    SEEK = 1'b0,
    SYNC = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    com_cnt;
  logic [CNT_W-1:0]    com_cnt_nxt;
  logic [LANE_W-1:0]   byte_cnt;
  logic [LANE_W-1:0]   byte_cnt_nxt;
  logic [WORD_W-1:0]   shadow;
  logic [WORD_W-1:0]   shadow_nxt;
  logic [WORD_W-1:0]   data_nxt;
  logic                valid_nxt;
  logic                active_nxt;
  logic                error_nxt;
  logic [ERR_W-1:0]    err_nxt;

  logic                is_com_c;
  logic [WORD_W-1:0]   lane_word_c;

  assign is_com_c = (data_in == COM);

  // Shadow with the incoming byte dropped into the lane selected by byte_cnt.
  always_comb begin
    lane_word_c = shadow;
    case (byte_cnt)
      2'd0:    lane_word_c[31:24] = data_in;
      2'd1:    lane_word_c[23:16] = data_in;
      2'd2:    lane_word_c[15:8]  = data_in;
      default: lane_word_c[7:0]   = data_in;
    endcase
  end

  // Next-state and output decode; only strobed edges make progress.
  always_comb begin
    state_nxt    = state;
    com_cnt_nxt  = com_cnt;
    byte_cnt_nxt = byte_cnt;
    shadow_nxt   = shadow;
    data_nxt     = data_out;
    valid_nxt    = 1'b0;
    active_nxt   = active;
    error_nxt    = 1'b0;
    err_nxt      = err_count;

    if (valid_in) begin
      if (state == SEEK) begin
        if (is_com_c) begin
          if (com_cnt == COM_LAST) begin
            state_nxt   = SYNC;
            active_nxt  = 1'b1;
            com_cnt_nxt = '0;
          end else begin
            com_cnt_nxt = com_cnt + 1'b1;
          end
        end else begin
          com_cnt_nxt = '0;
        end
      end else begin
        if (is_com_c) begin
          // COM at a word boundary is idle fill; mid-word it breaks the word.
          if (byte_cnt != '0) begin
            byte_cnt_nxt = '0;
            shadow_nxt   = '0;
            error_nxt    = 1'b1;
            if (err_count != ERR_MAX) begin
              err_nxt = err_count + 1'b1;
            end
          end
        end else begin
          byte_cnt_nxt = byte_cnt + 1'b1;
          if (byte_cnt == LANE_LAST) begin
            data_nxt   = lane_word_c;
            valid_nxt  = 1'b1;
            shadow_nxt = '0;
          end else begin
            shadow_nxt = lane_word_c;
          end
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state     <= SEEK;
      com_cnt   <= '0;
      byte_cnt  <= '0;
      shadow    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      error_out <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      com_cnt   <= com_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      shadow    <= shadow_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      active    <= active_nxt;
      error_out <= error_nxt;
      err_count <= err_nxt;
    end
  end

  logic unused_c;
  assign unused_c = ^{BYTE_W[0]};

endmodule

// File: tb/tb_palabra_8_32_rx.sv
// Directed bench for palabra_8_32_rx: sync search, word packing, idle,
// broken words, gapped strobes, reset behaviour and error saturation.
module tb_palabra_8_32_rx;

  logic        clk_4f;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;
  logic        error_out;
  logic [7:0]  err_count;

  int checks;
  int failures;
  int vpulses;
  int epulses;

  palabra_8_32_rx #(.COM(8'hBC), .SYNC_CNT(4)) dut (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active),
    .error_out(error_out),
    .err_count(err_count)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  // Pulse counters sampled mid-cycle.
  initial begin
    vpulses = 0;
    epulses = 0;
    forever begin
      @(negedge clk_4f);
      if (valid_out === 1'b1) vpulses++;
      if (error_out === 1'b1) epulses++;
    end
  end

  // One strobed byte; returns #1 after the consuming edge.
  task automatic send_byte(input logic [7:0] b);
    data_in  = b;
    valid_in = 1'b1;
    @(posedge clk_4f);
    #1;
    valid_in = 1'b0;
    data_in  = 8'h00;
  endtask

  task automatic idle_cycle();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    valid_in = 1'b0;
    data_in  = 8'h00;
    reset    = 1'b1;
    repeat (2) @(posedge clk_4f);
    #1;
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", data_out, 32'h0); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error_out); end
    checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL reset_errcnt got=%h exp=00", err_count); end
    reset = 1'b0;
  endtask

  task automatic test_sync();
    logic [7:0] w [4];
    int v0;
    w = '{8'hF2, 8'h15, 8'hDD, 8'h45};
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hBC);
      checks++; if (active !== 1'b0) begin failures++; $display("FAIL sync_early_active i=%0d got=%b exp=0", i, active); end
    end
    send_byte(8'hBC);
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL sync_active got=%b exp=1", active); end
    v0 = vpulses;
    for (int i = 0; i < 3; i++) begin
      send_byte(w[i]);
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL sync_partial_valid i=%0d got=%b exp=0", i, valid_out); end
      checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL sync_partial_data i=%0d got=%h exp=0", i, data_out); end
    end
    send_byte(w[3]);
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL sync_word_valid got=%b exp=1", valid_out); end
    checks++; if (data_out !== 32'hF215DD45) begin failures++; $display("FAIL sync_word_data got=%h exp=F215DD45", data_out); end
    idle_cycle();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL sync_valid_drop got=%b exp=0", valid_out); end
    checks++; if (vpulses - v0 !== 1) begin failures++; $display("FAIL sync_pulse_count got=%0d exp=1", vpulses - v0); end
  endtask

  task automatic test_idle_second();
    logic [7:0] w [4];
    int v0;
    w = '{8'hAA, 8'hEE, 8'h13, 8'hCD};
    v0 = vpulses;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hBC);
      checks++; if (valid_out !== 1'b0 || error_out !== 1'b0) begin failures++; $display("FAIL idle_quiet i=%0d got=%b%b exp=00", i, valid_out, error_out); end
      checks++; if (data_out !== 32'hF215DD45) begin failures++; $display("FAIL idle_hold i=%0d got=%h exp=F215DD45", i, data_out); end
    end
    for (int i = 0; i < 3; i++) send_byte(w[i]);
    checks++; if (data_out !== 32'hF215DD45) begin failures++; $display("FAIL second_hold got=%h exp=F215DD45", data_out); end
    send_byte(w[3]);
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL second_valid got=%b exp=1", valid_out); end
    checks++; if (data_out !== 32'hAAEE13CD) begin failures++; $display("FAIL second_data got=%h exp=AAEE13CD", data_out); end
    idle_cycle();
    checks++; if (vpulses - v0 !== 1) begin failures++; $display("FAIL second_pulse_count got=%0d exp=1", vpulses - v0); end
    checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL second_errcnt got=%h exp=00", err_count); end
  endtask

  task automatic test_partial();
    logic [7:0] w [4];
    int e0;
    w = '{8'h13, 8'hCD, 8'h45, 8'hDD};
    e0 = epulses;
    send_byte(8'hAA);
    send_byte(8'hEE);
    send_byte(8'hBC);
    checks++; if (error_out !== 1'b1) begin failures++; $display("FAIL partial_error got=%b exp=1", error_out); end
    checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL partial_errcnt got=%h exp=01", err_count); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL partial_valid got=%b exp=0", valid_out); end
    idle_cycle();
    checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL partial_error_drop got=%b exp=0", error_out); end
    for (int i = 0; i < 3; i++) begin
      send_byte(w[i]);
      checks++; if (data_out !== 32'hAAEE13CD) begin failures++; $display("FAIL partial_hold i=%0d got=%h exp=AAEE13CD", i, data_out); end
    end
    send_byte(w[3]);
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL partial_word_valid got=%b exp=1", valid_out); end
    checks++; if (data_out !== 32'h13CD45DD) begin failures++; $display("FAIL partial_word_data got=%h exp=13CD45DD", data_out); end
    idle_cycle();
    checks++; if (epulses - e0 !== 1) begin failures++; $display("FAIL partial_error_count got=%0d exp=1", epulses - e0); end
  endtask

  task automatic test_gapped();
    logic [7:0] w [4];
    int v0;
    w = '{8'hF2, 8'h15, 8'hDD, 8'h45};
    v0 = vpulses;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[i]);
      if (i < 3) begin
        for (int g = 0; g < 7; g++) begin
          idle_cycle();
          checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL gap_valid i=%0d g=%0d got=%b exp=0", i, g, valid_out); end
        end
        checks++; if (data_out !== 32'h13CD45DD) begin failures++; $display("FAIL gap_hold i=%0d got=%h exp=13CD45DD", i, data_out); end
      end
    end
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL gap_word_valid got=%b exp=1", valid_out); end
    checks++; if (data_out !== 32'hF215DD45) begin failures++; $display("FAIL gap_word_data got=%h exp=F215DD45", data_out); end
    repeat (3) idle_cycle();
    checks++; if (vpulses - v0 !== 1) begin failures++; $display("FAIL gap_pulse_count got=%0d exp=1", vpulses - v0); end
  endtask

  task automatic test_reset_mid_word();
    int v0;
    send_byte(8'hF2);
    send_byte(8'h15);
    // Reset edge with a live strobe; the byte must be ignored.
    reset    = 1'b1;
    data_in  = 8'hDD;
    valid_in = 1'b1;
    idle_cycle();
    reset    = 1'b0;
    valid_in = 1'b0;
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", data_out); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL rst_mid_active got=%b exp=0", active); end
    checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL rst_mid_errcnt got=%h exp=00", err_count); end
    checks++; if (valid_out !== 1'b0 || error_out !== 1'b0) begin failures++; $display("FAIL rst_mid_pulses got=%b%b exp=00", valid_out, error_out); end
    v0 = vpulses;
    send_byte(8'hDD);
    send_byte(8'h45);
    send_byte(8'h11);
    send_byte(8'h22);
    idle_cycle();
    checks++; if (vpulses - v0 !== 0) begin failures++; $display("FAIL rst_mid_no_word got=%0d exp=0", vpulses - v0); end
    checks++; if (active !== 1'b0 || data_out !== 32'h0) begin failures++; $display("FAIL rst_mid_seek got=%b/%h exp=0/0", active, data_out); end
  endtask

  task automatic test_broken_sync();
    logic [7:0] seq [8];
    seq = '{8'hBC, 8'hBC, 8'hBC, 8'hF2, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_byte(seq[i]);
      if (i < 7) begin
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL broken_active i=%0d got=%b exp=0", i, active); end
      end else begin
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL broken_final_active got=%b exp=1", active); end
      end
    end
    checks++; if (valid_out !== 1'b0 || error_out !== 1'b0) begin failures++; $display("FAIL broken_pulses got=%b%b exp=00", valid_out, error_out); end
  endtask

  task automatic test_err_saturate();
    for (int k = 1; k <= 260; k++) begin
      send_byte(8'h77);
      send_byte(8'hBC);
      if (k == 254) begin
        checks++; if (err_count !== 8'hFE) begin failures++; $display("FAIL sat_254 got=%h exp=FE", err_count); end
      end
      if (k == 255) begin
        checks++; if (err_count !== 8'hFF) begin failures++; $display("FAIL sat_255 got=%h exp=FF", err_count); end
      end
    end
    checks++; if (err_count !== 8'hFF) begin failures++; $display("FAIL sat_hold got=%h exp=FF", err_count); end
    checks++; if (error_out !== 1'b1) begin failures++; $display("FAIL sat_pulse got=%b exp=1", error_out); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL sat_active got=%b exp=1", active); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    test_reset();
    test_sync();
    test_idle_second();
    test_partial();
    test_gapped();
    test_reset_mid_word();
    test_broken_sync();
    test_err_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
